// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC register, single-outstanding SRAM request
// and a 2-entry registered FIFO towards decode.
// Optional build macro: IF_ADEL_CHECK_EN. It enables misaligned-fetch detection,
// which turns a fetch from an unaligned address into an address-error entry.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_adel
);

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic [31:0] r_pc_f;
    logic        r_inflight;
    logic [31:0] r_inf_pc;
    logic        r_head;
    logic [1:0]  r_count;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
`ifdef IF_ADEL_CHECK_EN
    logic        r_inf_adel;
    logic        r_halt;
    logic        r_fifo_adel  [2];
`endif

    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occ;
    logic        w_slot;
    logic        w_issue;
    logic        w_adel_iss;
    logic        w_wr_idx;

    // Issue/push/pop decisions and the decode-facing outputs.
    always_comb begin
        w_valid  = (r_count != 2'd0) && !rst;
        w_pop    = w_valid && id_ready;
        w_push   = r_inflight && !redirect && !rst;
        // Slots committed after this cycle: entries held plus the response on its way.
        w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_slot   = !redirect && !rst && (w_occ < 3'd2);
        // Tail slot; at count 2 a push only ever coincides with a pop of the head.
        w_wr_idx = r_head ^ r_count[0];
`ifdef IF_ADEL_CHECK_EN
        w_slot         = w_slot && !r_halt;
        w_issue        = w_slot && (r_pc_f[1:0] == 2'b00);
        w_adel_iss     = w_slot && (r_pc_f[1:0] != 2'b00);
        inst_sram_addr = r_pc_f;
        id_adel        = w_valid && r_fifo_adel[r_head];
`else
        w_issue        = w_slot;
        w_adel_iss     = 1'b0;
        inst_sram_addr = {r_pc_f[31:2], 2'b00};
        id_adel        = 1'b0;
`endif
        inst_sram_en = w_issue;
        id_valid     = w_valid;
        id_instr     = w_valid ? r_fifo_instr[r_head] : 32'h0;
        // id_pc carries the full fetch PC, including any low address bits.
        id_pc        = w_valid ? r_fifo_pc[r_head] : 32'h0;
    end

    // Control state: PC, outstanding request, FIFO pointers; redirect flushes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f     <= RESET_PC;
            r_inflight <= 1'b0;
            r_inf_pc   <= 32'h0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
`ifdef IF_ADEL_CHECK_EN
            r_inf_adel <= 1'b0;
            r_halt     <= 1'b0;
`endif
        end else if (redirect) begin
            r_pc_f     <= redirect_pc;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
`ifdef IF_ADEL_CHECK_EN
            r_inf_adel <= 1'b0;
            r_halt     <= 1'b0;
`endif
        end else begin
            // An address-error slot behaves like an issue that returns no data.
            r_inflight <= w_issue || w_adel_iss;
            if (w_issue || w_adel_iss) begin
                r_inf_pc <= r_pc_f;
            end
            if (w_issue) begin
                r_pc_f <= r_pc_f + 32'd4;
            end
`ifdef IF_ADEL_CHECK_EN
            r_inf_adel <= w_adel_iss;
            if (w_adel_iss) begin
                r_halt <= 1'b1;
            end
`endif
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // FIFO payload storage; contents are don't-care while count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[w_wr_idx] <= r_inf_pc;
`ifdef IF_ADEL_CHECK_EN
            r_fifo_instr[w_wr_idx] <= r_inf_adel ? 32'h0 : inst_sram_rdata;
            r_fifo_adel[w_wr_idx]  <= r_inf_adel;
`else
            r_fifo_instr[w_wr_idx] <= inst_sram_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: per-cycle directed vectors plus hand sequences.
// The SRAM model returns the request address as the instruction word.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_adel;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } vec_t;

    vec_t vecs [19];

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_adel        (id_adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle-latency SRAM echoing the address.
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? inst_sram_addr : 32'hDEAD_BEEF;
    end

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd,
                                input logic [31:0] rpc, input logic en,
                                input logic [31:0] addr, input logic vld,
                                input logic [31:0] pc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
        v.en = en; v.addr = addr; v.vld = vld; v.pc = vld ? pc : 32'h0;
        v.instr = vld ? pc : 32'h0;
        v.adel = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cycle %0d %s: got %h want %h", cyc, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        id_ready    = v.rdy;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        #1;
        chk("inst_sram_en", 32'(inst_sram_en), 32'(v.en));
        if (v.en) chk("inst_sram_addr", inst_sram_addr, v.addr);
        chk("id_valid", 32'(id_valid), 32'(v.vld));
        chk("id_pc", id_pc, v.pc);
        chk("id_instr", id_instr, v.instr);
        chk("id_adel", 32'(id_adel), 32'(v.adel));
        cyc++;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset, streaming start, 5-cycle stall, resume, redirect with id_ready=0.
        vecs[0]  = mk(1, 1, 0, 32'h0, 0, 32'h0,         0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0000, 0, 32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0004, 0, 32'h0);
        vecs[3]  = mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0008, 1, 32'hBFC0_0000);
        vecs[4]  = mk(0, 1, 0, 32'h0, 1, 32'hBFC0_000C, 1, 32'hBFC0_0004);
        for (int i = 5; i < 10; i++) begin
            vecs[i] = mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hBFC0_0008);
        end
        vecs[10] = mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0010, 1, 32'hBFC0_0008);
        vecs[11] = mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0014, 1, 32'hBFC0_000C);
        vecs[12] = mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0018, 1, 32'hBFC0_0010);
        vecs[13] = mk(0, 1, 0, 32'h0, 1, 32'hBFC0_001C, 1, 32'hBFC0_0014);
        vecs[14] = mk(0, 0, 1, 32'h8000_0100, 0, 32'h0, 1, 32'hBFC0_0018);
        vecs[15] = mk(0, 1, 0, 32'h0, 1, 32'h8000_0100, 0, 32'h0);
        vecs[16] = mk(0, 1, 0, 32'h0, 1, 32'h8000_0104, 0, 32'h0);
        vecs[17] = mk(0, 1, 0, 32'h0, 1, 32'h8000_0108, 1, 32'h8000_0100);
        vecs[18] = mk(0, 1, 0, 32'h0, 1, 32'h8000_010C, 1, 32'h8000_0104);

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i]);
        end

`ifdef IF_ADEL_CHECK_EN
        // Misaligned redirect: no request, one adel entry, halt until redirect.
        apply(mk(0, 1, 1, 32'h8000_0102, 0, 32'h0, 1, 32'h8000_0108));
        apply(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        v = mk(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h8000_0102);
        v.instr = 32'h0;
        v.adel  = 1'b1;
        apply(v);
        apply(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        apply(mk(0, 1, 1, 32'h8000_0180, 0, 32'h0, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 1, 32'h8000_0180, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 1, 32'h8000_0184, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 1, 32'h8000_0188, 1, 32'h8000_0180));
`else
        // Misaligned redirect without the check: address low bits forced to zero.
        apply(mk(0, 1, 1, 32'h8000_0102, 0, 32'h0, 1, 32'h8000_0108));
        apply(mk(0, 1, 0, 32'h0, 1, 32'h8000_0100, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 1, 32'h8000_0104, 0, 32'h0));
        v = mk(0, 1, 0, 32'h0, 1, 32'h8000_0108, 1, 32'h8000_0102);
        v.instr = 32'h8000_0100;
        apply(v);
`endif

        // One-cycle reset mid-stream: everything dropped, restart at the reset vector.
        apply(mk(1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0000, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0004, 0, 32'h0));
        apply(mk(0, 1, 0, 32'h0, 1, 32'hBFC0_0008, 1, 32'hBFC0_0000));
        apply(mk(0, 1, 0, 32'h0, 1, 32'hBFC0_000C, 1, 32'hBFC0_0004));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
